pps_monitor: RTL

Multi-channel, parametrised pulse-per-second front end. It is the successor to the single-channel PPS edge detector. Each channel synchronises an asynchronous PPS input through a configurable-depth flop chain and rejects glitches with a minimum-high filter. It then measures the interval between accepted edges and tracks lock against a nominal period with tolerance. The block sits between the board PPS pins and the timestamping/discipline logic, which consumes `pps_valid`, `locked` and `period_q`.

---
 rtl/pps_monitor_pkg.sv | 24 ++
 rtl/pps_monitor_chan.sv | 160 ++++++++++++++++
 rtl/pps_monitor.sv | 45 ++++
 3 files changed

// File: rtl/pps_monitor_pkg.sv
// Shared types and width helpers for the multi-channel PPS monitor.
// Optional glitch filter: define PPS_MONITOR_GLITCH_FILTER_EN.
package pps_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    function automatic int cnt_w(
        input int clk_hz,
        input int tol
    );
        return $clog2(clk_hz + tol + 2);
    endfunction

    function automatic int good_w(
        input int lock_count
    );
        return (lock_count < 2) ? 1 : $clog2(lock_count + 1);
    endfunction

endpackage

// File: rtl/pps_monitor_chan.sv
// One PPS channel: synchroniser, edge qualifier, period counter, lock FSM.
// Define PPS_MONITOR_GLITCH_FILTER_EN to build the minimum-high filter.
module pps_monitor_chan
    import pps_monitor_pkg::*;
#(
    parameter int SYNC_STAGES = 3,
    parameter int CLK_HZ      = 100_000_000,
    parameter int TOL_CYCLES  = 1000,
    parameter int MIN_HIGH    = 4,
    parameter int LOCK_COUNT  = 3,
    localparam int CNT_W      = cnt_w(CLK_HZ, TOL_CYCLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pps_in,
    output logic             pps_edge,
    output logic             pps_valid,
    output logic             period_err,
    output logic             missing,
    output logic             locked,
    output logic [CNT_W-1:0] period_q
);

    localparam int GOOD_W = good_w(LOCK_COUNT);

    localparam logic [CNT_W-1:0] CNT_LO  =
        CNT_W'(CLK_HZ - TOL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_HI  =
        CNT_W'(CLK_HZ + TOL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX =
        CNT_W'(CLK_HZ + TOL_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [GOOD_W-1:0] GOOD_MAX =
        GOOD_W'(LOCK_COUNT);
    localparam logic [GOOD_W-1:0] GOOD_ONE = GOOD_W'(1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic                   acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pps_in};
        end
    end

    assign s = sync[SYNC_STAGES-1];

`ifdef PPS_MONITOR_GLITCH_FILTER_EN
    localparam int HCNT_W = $clog2(MIN_HIGH + 1);
    localparam logic [HCNT_W-1:0] HCNT_MAX =
        HCNT_W'(MIN_HIGH);
    localparam logic [HCNT_W-1:0] HCNT_ARM =
        HCNT_W'(MIN_HIGH - 1);
    localparam logic [HCNT_W-1:0] HCNT_ONE = HCNT_W'(1);

    logic [HCNT_W-1:0] hcnt;

    // acc fires on the MIN_HIGH-th consecutive high sample only
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt <= '0;
            acc  <= 1'b0;
        end else begin
            acc <= s && (hcnt == HCNT_ARM);
            if (!s) begin
                hcnt <= '0;
            end else if (hcnt != HCNT_MAX) begin
                hcnt <= hcnt + HCNT_ONE;
            end
        end
    end
`else
    logic s_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q <= 1'b0;
            acc <= 1'b0;
        end else begin
            s_q <= s;
            acc <= s & ~s_q;
        end
    end
`endif

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [GOOD_W-1:0] good;
    logic [GOOD_W-1:0] good_inc;
    logic              in_tol;
    logic              timeout;

    assign in_tol   = (cnt >= CNT_LO) && (cnt <= CNT_HI);
    assign timeout  = (cnt == CNT_MAX);
    assign good_inc = (good == GOOD_MAX) ? good
                                         : good + GOOD_ONE;
    assign locked   = (state == LOCKED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            good       <= '0;
            period_q   <= '0;
            pps_edge   <= 1'b0;
            pps_valid  <= 1'b0;
            period_err <= 1'b0;
            missing    <= 1'b0;
        end else begin
            pps_edge   <= acc;
            pps_valid  <= 1'b0;
            period_err <= 1'b0;
            missing    <= 1'b0;

            if (acc) begin
                cnt <= CNT_ONE;
            end else if (!timeout) begin
                cnt <= cnt + CNT_ONE;
            end

            // an edge always wins over a coincident timeout
            unique case (state)
                IDLE: begin
                    if (acc) begin
                        state <= MEASURE;
                    end
                end
                MEASURE, LOCKED: begin
                    if (acc) begin
                        period_q <= cnt;
                        if (in_tol) begin
                            pps_valid <= 1'b1;
                            good      <= good_inc;
                            if (good_inc == GOOD_MAX) begin
                                state <= LOCKED;
                            end
                        end else begin
                            period_err <= 1'b1;
                            good       <= '0;
                            state      <= MEASURE;
                        end
                    end else if (timeout) begin
                        missing <= 1'b1;
                        good    <= '0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    good  <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/pps_monitor.sv
// Multi-channel PPS front end: one independent pps_monitor_chan per input.
// Optional glitch filter: define PPS_MONITOR_GLITCH_FILTER_EN.
module pps_monitor
    import pps_monitor_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int SYNC_STAGES = 3,
    parameter int CLK_HZ      = 100_000_000,
    parameter int TOL_CYCLES  = 1000,
    parameter int MIN_HIGH    = 4,
    parameter int LOCK_COUNT  = 3,
    localparam int CNT_W      = cnt_w(CLK_HZ, TOL_CYCLES)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CHANNELS-1:0]            pps_in,
    output logic [CHANNELS-1:0]            pps_edge,
    output logic [CHANNELS-1:0]            pps_valid,
    output logic [CHANNELS-1:0]            period_err,
    output logic [CHANNELS-1:0]            missing,
    output logic [CHANNELS-1:0]            locked,
    output logic [CHANNELS-1:0][CNT_W-1:0] period_q
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        pps_monitor_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .CLK_HZ      (CLK_HZ),
            .TOL_CYCLES  (TOL_CYCLES),
            .MIN_HIGH    (MIN_HIGH),
            .LOCK_COUNT  (LOCK_COUNT)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .pps_in     (pps_in[i]),
            .pps_edge   (pps_edge[i]),
            .pps_valid  (pps_valid[i]),
            .period_err (period_err[i]),
            .missing    (missing[i]),
            .locked     (locked[i]),
            .period_q   (period_q[i])
        );
    end

endmodule
